// File: rtl/peb_psum_wb_arb.sv
// ---------------------------------------------------------------------------
// peb_psum_wb_arb
//
// Write-back arbiter for one PEB. It merges the three partial-sum output
// streams of the PEB into a single global-buffer write port. Channels are
// granted round-robin, each channel owns a CH_DEPTH-entry region of the GB
// addressed by a wrapping per-channel pointer, and the selected beat is
// registered in a one-entry output stage with valid/ready backpressure.
//
// Optional feature macro: PEB_PSUM_WB_CNT_EN
//   defined   : per-channel 16-bit accepted-beat counters drive WB_cnt0/1/2
//   undefined : counters are not built, WB_cnt0/1/2 are tied to zero
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   clear                  synchronous pulse, zeroes all channel pointers
//   PSUMGB_val0/1/2        channel beat valid from the PEB
//   PSUMGB_data0/1/2       channel beat data (PSUM_WIDTH*NUM_PSUM bits)
//   GBPSUM_rdy0/1/2        channel ready back to the PEB (combinational)
//   WB_val, WB_rdy         output beat handshake
//   WB_data                registered output beat
//   WB_addr                GB write address of WB_data
//   WB_ch                  source channel of WB_data (0..2)
//   WB_cnt0/1/2            accepted-beat counters per channel
// ---------------------------------------------------------------------------
module peb_psum_wb_arb #(
    parameter int unsigned PSUM_WIDTH = 32,
    parameter int unsigned NUM_PSUM   = 16,
    parameter int unsigned CH_DEPTH   = 64,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           PSUMGB_val0,
    input  logic                           PSUMGB_val1,
    input  logic                           PSUMGB_val2,
    input  logic [PSUM_WIDTH*NUM_PSUM-1:0] PSUMGB_data0,
    input  logic [PSUM_WIDTH*NUM_PSUM-1:0] PSUMGB_data1,
    input  logic [PSUM_WIDTH*NUM_PSUM-1:0] PSUMGB_data2,
    output logic                           GBPSUM_rdy0,
    output logic                           GBPSUM_rdy1,
    output logic                           GBPSUM_rdy2,
    output logic                           WB_val,
    input  logic                           WB_rdy,
    output logic [PSUM_WIDTH*NUM_PSUM-1:0] WB_data,
    output logic [ADDR_WIDTH-1:0]          WB_addr,
    output logic [1:0]                     WB_ch,
    output logic [15:0]                    WB_cnt0,
    output logic [15:0]                    WB_cnt1,
    output logic [15:0]                    WB_cnt2
);

    localparam int unsigned BEAT_W = PSUM_WIDTH * NUM_PSUM;
    localparam int unsigned PTR_W  = (CH_DEPTH > 1) ? $clog2(CH_DEPTH) : 1;

    // Extra always-zero bit keeps every 2-bit channel index in range.
    logic [3:0]        val;
    logic [1:0]        last;
    logic [PTR_W-1:0]  ptr [3];

    logic              slot_free;
    logic              win_any;
    logic [1:0]        winner;
    logic [1:0]        cand1;
    logic [1:0]        cand2;
    logic              grant;
    logic [BEAT_W-1:0] sel_data;
    logic [PTR_W-1:0]  sel_ptr;
    logic [ADDR_WIDTH-1:0] sel_addr;

    assign val = {1'b0, PSUMGB_val2, PSUMGB_val1, PSUMGB_val0};

    // The output register can take a new beat when it is empty or is being
    // drained in this very cycle.
    assign slot_free = !WB_val || WB_rdy;

    // Search order last+1, last+2, last (mod 3).
    assign cand1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
    assign cand2 = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;

    always_comb begin
        win_any = 1'b1;
        winner  = 2'd0;
        if (val[cand1]) begin
            winner = cand1;
        end else if (val[cand2]) begin
            winner = cand2;
        end else if (val[last]) begin
            winner = last;
        end else begin
            win_any = 1'b0;
        end
    end

    assign grant = win_any && slot_free;

    assign GBPSUM_rdy0 = grant && (winner == 2'd0);
    assign GBPSUM_rdy1 = grant && (winner == 2'd1);
    assign GBPSUM_rdy2 = grant && (winner == 2'd2);

    always_comb begin
        sel_data = PSUMGB_data0;
        sel_ptr  = ptr[0];
        case (winner)
            2'd1: begin
                sel_data = PSUMGB_data1;
                sel_ptr  = ptr[1];
            end
            2'd2: begin
                sel_data = PSUMGB_data2;
                sel_ptr  = ptr[2];
            end
            default: begin
                sel_data = PSUMGB_data0;
                sel_ptr  = ptr[0];
            end
        endcase
    end

    // Channel i owns GB entries [i*CH_DEPTH, (i+1)*CH_DEPTH).
    assign sel_addr = ADDR_WIDTH'(ADDR_WIDTH'(winner) * ADDR_WIDTH'(CH_DEPTH))
                    + ADDR_WIDTH'(sel_ptr);

    // Output stage, arbitration history and address pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_val  <= 1'b0;
            WB_data <= '0;
            WB_addr <= '0;
            WB_ch   <= 2'd0;
            last    <= 2'd2;
            for (int k = 0; k < 3; k++) begin
                ptr[k] <= '0;
            end
        end else begin
            if (grant) begin
                WB_val  <= 1'b1;
                WB_data <= sel_data;
                WB_addr <= sel_addr;
                WB_ch   <= winner;
                last    <= winner;
            end else if (WB_val && WB_rdy) begin
                WB_val <= 1'b0;
            end

            // clear takes precedence over the increment of a same-cycle
            // grant; that grant has already used the old pointer above.
            for (int k = 0; k < 3; k++) begin
                if (clear) begin
                    ptr[k] <= '0;
                end else if (grant && (winner == 2'(k))) begin
                    ptr[k] <= ptr[k] + 1'b1;
                end
            end
        end
    end

`ifdef PEB_PSUM_WB_CNT_EN
    logic [15:0] cnt [3];
    logic [2:0]  xfer;

    // A ready is only ever raised for a valid channel, so ready alone marks
    // an input transfer.
    assign xfer = {GBPSUM_rdy2, GBPSUM_rdy1, GBPSUM_rdy0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                cnt[k] <= 16'd0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (xfer[k]) begin
                    cnt[k] <= cnt[k] + 16'd1;
                end
            end
        end
    end

    assign WB_cnt0 = cnt[0];
    assign WB_cnt1 = cnt[1];
    assign WB_cnt2 = cnt[2];
`else
    assign WB_cnt0 = 16'd0;
    assign WB_cnt1 = 16'd0;
    assign WB_cnt2 = 16'd0;
`endif

endmodule

// File: tb/tb_peb_psum_wb_arb.sv
// ---------------------------------------------------------------------------
// Self-checking bench for peb_psum_wb_arb. Inputs change 2 time units after
// the rising edge; readies and output transfers are sampled on the falling
// edge, and output registers are inspected 1 time unit after the rising edge.
// Expected beats are queued when the bench drives a beat it expects to be
// granted and are compared by the output monitor at each output transfer.
// ---------------------------------------------------------------------------
module tb_peb_psum_wb_arb;

    localparam int BW = 512;

`ifdef PEB_PSUM_WB_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          v0, v1, v2;
    logic [BW-1:0] d0, d1, d2;
    logic          r0, r1, r2;
    logic          WB_val;
    logic          WB_rdy;
    logic [BW-1:0] WB_data;
    logic [7:0]    WB_addr;
    logic [1:0]    WB_ch;
    logic [15:0]   WB_cnt0, WB_cnt1, WB_cnt2;
    logic [2:0]    rdy_v;

    assign rdy_v = {r2, r1, r0};

    always #5 clk = ~clk;

    peb_psum_wb_arb dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .PSUMGB_val0  (v0),
        .PSUMGB_val1  (v1),
        .PSUMGB_val2  (v2),
        .PSUMGB_data0 (d0),
        .PSUMGB_data1 (d1),
        .PSUMGB_data2 (d2),
        .GBPSUM_rdy0  (r0),
        .GBPSUM_rdy1  (r1),
        .GBPSUM_rdy2  (r2),
        .WB_val       (WB_val),
        .WB_rdy       (WB_rdy),
        .WB_data      (WB_data),
        .WB_addr      (WB_addr),
        .WB_ch        (WB_ch),
        .WB_cnt0      (WB_cnt0),
        .WB_cnt1      (WB_cnt1),
        .WB_cnt2      (WB_cnt2)
    );

    typedef struct {
        logic [BW-1:0] data;
        logic [7:0]    addr;
        logic [1:0]    ch;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;
    int    n_cmp = 0;
    int    n_err = 0;
    int    tb_ptr[3];
    int    exp_cnt[3];
    int    tag = 0;

    function automatic logic [BW-1:0] mk_data(input int t);
        logic [BW-1:0] d;
        for (int j = 0; j < 16; j++) begin
            d[j*32 +: 32] = 32'(t * 16 + j) ^ 32'hA5C3_0000;
        end
        return d;
    endfunction

    // Put a fresh beat on channel ch (data only).
    task automatic set_data(input int ch);
        logic [BW-1:0] d;
        d = mk_data(tag);
        tag++;
        case (ch)
            0: d0 = d;
            1: d1 = d;
            default: d2 = d;
        endcase
    endtask

    // Queue the beat currently presented on channel ch as the next expected
    // output and advance the bench's address/count model.
    task automatic expect_accept(input int ch);
        beat_t b;
        case (ch)
            0: b.data = d0;
            1: b.data = d1;
            default: b.data = d2;
        endcase
        b.addr = 8'(ch * 64 + tb_ptr[ch]);
        b.ch   = 2'(ch);
        sb.push_back(b);
        tb_ptr[ch] = (tb_ptr[ch] + 1) % 64;
        exp_cnt[ch] = (exp_cnt[ch] + 1) % 65536;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        clear  = 1'b0;
        v0     = 1'b0;
        v1     = 1'b0;
        v2     = 1'b0;
        WB_rdy = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            tb_ptr[k]  = 0;
            exp_cnt[k] = 0;
        end
        cyc();
    endtask

    // Output monitor: every transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && WB_val && WB_rdy) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_extra_beat: got ch=%0d addr=%0d, required no beat",
                         WB_ch, WB_addr);
            end else begin
                mon_e = sb.pop_front();
                if (WB_data !== mon_e.data || WB_addr !== mon_e.addr || WB_ch !== mon_e.ch) begin
                    n_err++;
                    $display("FAIL sb_beat: got ch=%0d addr=%0d data[31:0]=%h, required ch=%0d addr=%0d data[31:0]=%h",
                             WB_ch, WB_addr, WB_data[31:0], mon_e.ch, mon_e.addr,
                             mon_e.data[31:0]);
                end
            end
        end
    end

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if (WB_val !== 1'b0) begin
            n_err++; $display("FAIL reset_val: got %b, required 0", WB_val);
        end
        n_cmp++;
        if (WB_data !== '0) begin
            n_err++; $display("FAIL reset_data: got %h, required 0", WB_data[31:0]);
        end
        n_cmp++;
        if (WB_addr !== 8'd0) begin
            n_err++; $display("FAIL reset_addr: got %0d, required 0", WB_addr);
        end
        n_cmp++;
        if (WB_ch !== 2'd0) begin
            n_err++; $display("FAIL reset_ch: got %0d, required 0", WB_ch);
        end
        n_cmp++;
        if (rdy_v !== 3'b000) begin
            n_err++; $display("FAIL reset_rdy_idle: got %b, required 000", rdy_v);
        end
        n_cmp++;
        if ({WB_cnt0, WB_cnt1, WB_cnt2} !== 48'd0) begin
            n_err++; $display("FAIL reset_cnt: got %0d/%0d/%0d, required 0/0/0",
                              WB_cnt0, WB_cnt1, WB_cnt2);
        end
        cyc();
    endtask

    task automatic test_single_channel();
        do_reset();
        WB_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_data(1);
            v1 = 1'b1;
            expect_accept(1);
            @(negedge clk);
            n_cmp++;
            if (rdy_v !== 3'b010) begin
                n_err++; $display("FAIL single_rdy%0d: got %b, required 010", k, rdy_v);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (WB_val !== 1'b1 || WB_addr !== 8'(64 + k) || WB_ch !== 2'd1) begin
                n_err++;
                $display("FAIL single_latency%0d: got val=%b addr=%0d ch=%0d, required val=1 addr=%0d ch=1",
                         k, WB_val, WB_addr, WB_ch, 64 + k);
            end
            #1;
        end
        v1 = 1'b0;
        repeat (2) cyc();
        n_cmp++;
        if (WB_val !== 1'b0 || sb.size() != 0) begin
            n_err++; $display("FAIL single_drain: got val=%b pending=%0d, required val=0 pending=0",
                              WB_val, sb.size());
        end
    endtask

    task automatic test_rotation();
        int order [6] = '{0, 1, 2, 0, 1, 2};
        int addrs [6] = '{0, 64, 128, 1, 65, 129};
        do_reset();
        WB_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_data(0);
            set_data(1);
            set_data(2);
            v0 = 1'b1;
            v1 = 1'b1;
            v2 = 1'b1;
            expect_accept(order[i]);
            @(negedge clk);
            n_cmp++;
            if (rdy_v !== 3'(1 << order[i])) begin
                n_err++; $display("FAIL rot_rdy%0d: got %b, required %b", i, rdy_v,
                                  3'(1 << order[i]));
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (WB_addr !== 8'(addrs[i]) || WB_ch !== 2'(order[i])) begin
                n_err++; $display("FAIL rot_beat%0d: got addr=%0d ch=%0d, required addr=%0d ch=%0d",
                                  i, WB_addr, WB_ch, addrs[i], order[i]);
            end
            #1;
        end
        v0 = 1'b0;
        v1 = 1'b0;
        v2 = 1'b0;
        repeat (2) cyc();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL rot_drain: got pending=%0d, required 0", sb.size());
        end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] held;
        do_reset();
        WB_rdy = 1'b0;
        set_data(0);
        v0 = 1'b1;
        held = d0;
        expect_accept(0);
        @(negedge clk);
        n_cmp++;
        if (rdy_v !== 3'b001) begin
            n_err++; $display("FAIL bp_first_rdy: got %b, required 001", rdy_v);
        end
        cyc();
        set_data(0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (WB_val !== 1'b1 || WB_data !== held || rdy_v !== 3'b000) begin
                n_err++; $display("FAIL bp_hold%0d: got val=%b data[31:0]=%h rdy=%b, required val=1 data[31:0]=%h rdy=000",
                                  k, WB_val, WB_data[31:0], rdy_v, held[31:0]);
            end
            cyc();
        end
        WB_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) set_data(0);
            expect_accept(0);
            @(negedge clk);
            n_cmp++;
            if (rdy_v !== 3'b001) begin
                n_err++; $display("FAIL bp_release_rdy%0d: got %b, required 001", k, rdy_v);
            end
            cyc();
        end
        v0 = 1'b0;
        repeat (2) cyc();
        n_cmp++;
        if (WB_val !== 1'b0 || sb.size() != 0) begin
            n_err++; $display("FAIL bp_drain: got val=%b pending=%0d, required val=0 pending=0",
                              WB_val, sb.size());
        end
    endtask

    task automatic test_wrap_clear();
        do_reset();
        WB_rdy = 1'b1;
        v2 = 1'b1;
        for (int k = 0; k < 68; k++) begin
            set_data(2);
            clear = (k == 66);
            expect_accept(2);
            if (k == 66) tb_ptr[2] = 0;
            @(negedge clk);
            @(posedge clk);
            #1;
            if (k == 63 || k == 64 || k == 66 || k == 67) begin
                int req;
                req = (k == 63) ? 191 : (k == 66) ? 130 : 128;
                n_cmp++;
                if (WB_addr !== 8'(req)) begin
                    n_err++; $display("FAIL wrap_addr_k%0d: got %0d, required %0d", k, WB_addr, req);
                end
            end
            #1;
        end
        clear = 1'b0;
        v2 = 1'b0;
        repeat (2) cyc();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL wrap_drain: got pending=%0d, required 0", sb.size());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        WB_rdy = 1'b1;
        set_data(0);
        v0 = 1'b1;
        expect_accept(0);
        cyc();
        v0 = 1'b0;
        set_data(1);
        v1 = 1'b1;
        expect_accept(1);
        cyc();
        v1 = 1'b0;
        WB_rdy = 1'b0;
        cyc();
        n_cmp++;
        if (WB_val !== 1'b1 || WB_ch !== 2'd1 || WB_addr !== 8'd64) begin
            n_err++; $display("FAIL arst_pre: got val=%b ch=%0d addr=%0d, required val=1 ch=1 addr=64",
                              WB_val, WB_ch, WB_addr);
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (WB_val !== 1'b0 || WB_addr !== 8'd0 || WB_ch !== 2'd0) begin
            n_err++; $display("FAIL arst_immediate: got val=%b addr=%0d ch=%0d, required val=0 addr=0 ch=0",
                              WB_val, WB_addr, WB_ch);
        end
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            tb_ptr[k]  = 0;
            exp_cnt[k] = 0;
        end
        cyc();
        rst = 1'b0;
        WB_rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_data(0);
            set_data(1);
            set_data(2);
            v0 = 1'b1;
            v1 = 1'b1;
            v2 = 1'b1;
            expect_accept(i);
            @(negedge clk);
            n_cmp++;
            if (rdy_v !== 3'(1 << i)) begin
                n_err++; $display("FAIL arst_grant%0d: got %b, required %b", i, rdy_v, 3'(1 << i));
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (WB_addr !== 8'(i * 64) || WB_ch !== 2'(i)) begin
                n_err++; $display("FAIL arst_addr%0d: got addr=%0d ch=%0d, required addr=%0d ch=%0d",
                                  i, WB_addr, WB_ch, i * 64, i);
            end
            #1;
        end
        v0 = 1'b0;
        v1 = 1'b0;
        v2 = 1'b0;
        repeat (2) cyc();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL arst_drain: got pending=%0d, required 0", sb.size());
        end
    endtask

    task automatic test_counters();
        int req [3];
        do_reset();
        WB_rdy = 1'b1;
        for (int k = 0; k < 17; k++) begin
            int ch;
            ch = (k < 10) ? 0 : 1;
            set_data(ch);
            v0 = (ch == 0);
            v1 = (ch == 1);
            expect_accept(ch);
            cyc();
        end
        v0 = 1'b0;
        v1 = 1'b0;
        clear = 1'b1;
        for (int k = 0; k < 3; k++) tb_ptr[k] = 0;
        cyc();
        clear = 1'b0;
        repeat (2) cyc();
        for (int k = 0; k < 3; k++) req[k] = CNT_EN ? exp_cnt[k] : 0;
        n_cmp++;
        if (WB_cnt0 !== 16'(req[0]) || WB_cnt1 !== 16'(req[1]) || WB_cnt2 !== 16'(req[2])) begin
            n_err++; $display("FAIL cnt_values: got %0d/%0d/%0d, required %0d/%0d/%0d",
                              WB_cnt0, WB_cnt1, WB_cnt2, req[0], req[1], req[2]);
        end
        // Pointers were cleared: the next channel-0 beat lands at address 0.
        set_data(0);
        v0 = 1'b1;
        expect_accept(0);
        @(posedge clk);
        #1;
        n_cmp++;
        if (WB_addr !== 8'd0) begin
            n_err++; $display("FAIL cnt_clear_ptr: got addr=%0d, required 0", WB_addr);
        end
        #1;
        v0 = 1'b0;
        repeat (2) cyc();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL cnt_drain: got pending=%0d, required 0", sb.size());
        end
    endtask

    initial begin
        rst    = 1'b1;
        clear  = 1'b0;
        v0     = 1'b0;
        v1     = 1'b0;
        v2     = 1'b0;
        d0     = '0;
        d1     = '0;
        d2     = '0;
        WB_rdy = 1'b0;
        cyc();
        test_reset();
        test_single_channel();
        test_rotation();
        test_backpressure();
        test_wrap_clear();
        test_async_reset();
        test_counters();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/peb_psum_wb_arb.md
# peb_psum_wb_arb

Write-back arbiter directly downstream of one PEB's three partial-sum output ports (PSUMGB_val0/1/2, PSUMGB_data0/1/2). It merges the three 16×32-bit PSUM streams into a single global-buffer write port using round-robin arbitration. It generates a per-channel wrapping write address and registers the selected beat in a one-entry output stage with valid/ready backpressure. One instance per PEB, between inst_PEB and the PSUM global buffer.

## Interface
- PSUM_WIDTH, 32, bits per partial sum
- NUM_PSUM, 16, partial sums per beat (beat width = PSUM_WIDTH*NUM_PSUM)
- CH_DEPTH, 64, GB entries reserved per channel (power of two)
- ADDR_WIDTH, 8, write address width (must hold 3*CH_DEPTH-1)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous pulse; zeroes all channel address pointers
- PSUMGB_val0/1/2  in  1 each  PEB channel beat valid
- PSUMGB_data0/1/2  in  PSUM_WIDTH*NUM_PSUM each  channel beat data
- GBPSUM_rdy0/1/2  out  1 each  channel ready back to PEB
- WB_val  out  1  output beat valid
- WB_rdy  in  1  global buffer accepts beat
- WB_data  out  PSUM_WIDTH*NUM_PSUM  registered beat
- WB_addr  out  ADDR_WIDTH  GB write address
- WB_ch  out  2  source channel of WB_data (0..2)
- WB_cnt0/1/2  out  16 each  accepted-beat counters (see Configuration)

## Operation
- Transfer on channel i: PSUMGB_vali && GBPSUM_rdyi at posedge clk. Output transfer: WB_val && WB_rdy.
- Output slot is free when !WB_val, or when WB_val && WB_rdy in the same cycle.
- Round-robin: `last` holds the most recently granted channel; resets to 2, so channel 0 has first priority. Search order is last+1, last+2, last+3 (mod 3). The first valid channel wins.
- GBPSUM_rdyi = (i == winner) && slot free. Ready is combinational on vals, WB_val and WB_rdy. At most one rdy is high per cycle. Rdy is never high for a channel whose val is low.
- On grant of channel i: WB_data ← PSUMGB_datai, WB_ch ← i, WB_addr ← i*CH_DEPTH + ptr[i], WB_val ← 1, ptr[i] ← ptr[i]+1 (wraps CH_DEPTH-1 → 0), last ← i.
- On output transfer with no new grant: WB_val ← 0. WB_data, WB_addr and WB_ch hold their values.
- While WB_val && !WB_rdy, all output registers are held stable and all GBPSUM_rdy are 0.
- clear: all ptr ← 0. A grant in the same cycle as clear uses the pre-clear pointer for WB_addr, and its channel pointer ends at 0 (clear wins). clear does not affect WB_val/WB_data/last.
- Reset values: WB_val 0, WB_data 0, WB_addr 0, WB_ch 0, ptr[0..2] 0, last 2, WB_cnt* 0. Reset asserted mid-beat discards any pending output immediately.

## Timing
- Latency: input accept → WB_val high is 1 cycle.
- Throughput: one beat per cycle with WB_rdy held high. Grant rotates 0→1→2→0 when all three channels are valid.
- No combinational path from PSUMGB_data* to WB_data. Combinational paths exist from PSUMGB_val*, WB_rdy and WB_val to GBPSUM_rdy*.
- Address wrap is silent; overflow protection is the scheduler's responsibility.

## Configuration
- PEB_PSUM_WB_CNT_EN defined: WB_cnt[i] increments on each channel-i input transfer, wraps at 16'hFFFF → 0, is zeroed by rst, and is unaffected by clear.
- Undefined: counters are not built. WB_cnt0/1/2 are tied to 0, and the ports remain so that the instance wiring is identical.

## Test plan
- Single channel: after reset, val1=1 for 3 beats with WB_rdy=1 → WB_addr 64, 65, 66, WB_ch=1, each appearing 1 cycle after its accept.
- All-valid rotation: val0=val1=val2=1 continuously, WB_rdy=1 → grant order 0, 1, 2, 0, 1, 2; WB_addr 0, 64, 128, 1, 65, 129.
- Backpressure: WB_rdy=0 for 5 cycles with val0=1 → WB_val stays high, WB_data unchanged, GBPSUM_rdy0=0. Releasing WB_rdy gives one transfer per cycle with no beat lost or duplicated.
- Wrap and clear: 64 beats on channel 2 → last WB_addr 191, next 128. clear pulsed concurrently with a channel-2 grant → that beat's WB_addr is the pre-clear address, and the next channel-2 beat is 128.
- Async reset mid-stream: assert rst between edges while WB_val=1 → WB_val falls at once, and all ptr and last return to reset values. The first post-reset grant goes to channel 0.
- With PEB_PSUM_WB_CNT_EN: 10 beats ch0, 7 beats ch1, clear pulsed → WB_cnt0=10, WB_cnt1=7, WB_cnt2=0. Without the macro, all counters read 0.
